// File: rtl/bs_arbiter.sv
// Arbitrates NREQ requesters onto one shared external barrel shifter and buffers the results in a FWFT FIFO.
// Define BS_ARBITER_FIXED_PRIO_EN for fixed priority (lowest index wins); round-robin otherwise.
module bs_arbiter #(
  parameter int BIT_WIDTH = 8,
  parameter int N         = 16,
  parameter int NREQ      = 4,
  parameter int BS_LAT    = 1,
  localparam int W        = BIT_WIDTH * N,
  localparam int S        = (N > 1) ? $clog2(N) : 1,
  localparam int I        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_data,
  input  logic [NREQ*S-1:0] req_shift,
  output logic [W-1:0]      bs_in,
  output logic [S-1:0]      bs_shift,
  input  logic [W-1:0]      bs_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [W-1:0]      rsp_data,
  output logic [I-1:0]      rsp_id
);
  localparam int DEPTH = BS_LAT + 2;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [I-1:0] id;
    logic [W-1:0] data;
  } rsp_t;

  logic [NREQ-1:0][W-1:0]   data_a;
  logic [NREQ-1:0][S-1:0]   shift_a;
  logic [CW-1:0]            count, inflight;
  logic [PW-1:0]            wr_ptr, rd_ptr;
  rsp_t                     mem [DEPTH];
  logic [BS_LAT-1:0]        vld_pipe;
  logic [BS_LAT-1:0][I-1:0] id_pipe;
  logic                     found, credit_ok, issue, push, pop;
  logic [I-1:0]             gnt_id;

  assign data_a  = req_data;
  assign shift_a = req_shift;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

`ifdef BS_ARBITER_FIXED_PRIO_EN
  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        found  = 1'b1;
        gnt_id = I'(i);
      end
    end
  end
`else
  logic [I-1:0] ptr;
  logic [I:0]   cand;

  // Walk requesters starting at ptr, wrapping modulo NREQ.
  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    cand   = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr} + (I+1)'(i);
      if (cand >= (I+1)'(NREQ)) cand = cand - (I+1)'(NREQ);
      if (!found && req_valid[cand[I-1:0]]) begin
        found  = 1'b1;
        gnt_id = cand[I-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   ptr <= '0;
    else if (issue) ptr <= (gnt_id == I'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
  end
`endif

  // Credit counts registered occupancy only, so a pop frees a slot one cycle later.
  assign credit_ok = ({1'b0, count} + {1'b0, inflight}) < (CW+1)'(DEPTH);
  assign issue     = found && credit_ok && reset_n;
  assign req_ready = issue ? (NREQ'(1) << gnt_id) : '0;
  assign bs_in     = issue ? data_a[gnt_id] : '0;
  assign bs_shift  = issue ? shift_a[gnt_id] : '0;

  assign push      = vld_pipe[BS_LAT-1];
  assign rsp_valid = (count != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_data  = rsp_valid ? mem[rd_ptr].data : '0;
  assign rsp_id    = rsp_valid ? mem[rd_ptr].id : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
      inflight <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      vld_pipe[0] <= issue;
      id_pipe[0]  <= gnt_id;
      for (int k = 1; k < BS_LAT; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        id_pipe[k]  <= id_pipe[k-1];
      end
      if (issue && !push)      inflight <= inflight + 1'b1;
      else if (!issue && push) inflight <= inflight - 1'b1;
      if (push && !pop)        count <= count + 1'b1;
      else if (!push && pop)   count <= count - 1'b1;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{id: id_pipe[BS_LAT-1], data: bs_out};
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(push && count == CW'(DEPTH)));
  a_ready_valid: assert property (@(posedge clk) disable iff (!reset_n)
    (req_ready & ~req_valid) == '0);
endmodule

// File: doc/bs_arbiter.md
BS_ARBITER -- requirements
Module: bs_arbiter

Interface
REQ-001 Parameter BIT_WIDTH, default 8, element width in bits.
REQ-002 Parameter N, default 16, elements per word; word width W = BIT_WIDTH*N, shift width S = $clog2(N).
REQ-003 Parameter NREQ, default 4, number of requesters; ID width I = $clog2(NREQ).
REQ-004 Parameter BS_LAT, default 1, fixed shifter latency in cycles (>=1).
REQ-005 Port clk  input  1  sole clock, all logic on posedge.
REQ-006 Port reset_n  input  1  asynchronous, active-low reset.
REQ-007 Port req_valid  input  NREQ  per-requester request valid.
REQ-008 Port req_ready  output  NREQ  per-requester grant/accept, one-hot or zero.
REQ-009 Port req_data  input  NREQ*W  requester r word at [r*W +: W].
REQ-010 Port req_shift  input  NREQ*S  requester r shift amount at [r*S +: S].
REQ-011 Port bs_in  output  W  word driven to the shared shifter.
REQ-012 Port bs_shift  output  S  shift amount driven to the shared shifter.
REQ-013 Port bs_out  input  W  shifter result, valid BS_LAT cycles after issue.
REQ-014 Port rsp_valid  output  1  response available.
REQ-015 Port rsp_ready  input  1  downstream accepts response.
REQ-016 Port rsp_data  output  W  shifted word.
REQ-017 Port rsp_id  output  I  index of requester that issued rsp_data.

Function
REQ-018 Request r transfers on a cycle with req_valid[r] && req_ready[r]; at most one transfer per cycle.
REQ-019 req_ready SHALL be combinational from req_valid, arbitration pointer and credit; req_ready[r] SHALL never assert while req_valid[r] is low.
REQ-020 Issue allowed only when (fifo_count + inflight) < DEPTH, DEPTH = BS_LAT+2; a pop in the same cycle SHALL NOT release credit.
REQ-021 Round-robin: search starts at pointer p; first valid requester at or after p (mod NREQ) is granted; after a grant p = granted+1 mod NREQ; p unchanged when nothing granted.
REQ-022 On grant, bs_in/bs_shift SHALL carry the granted requester's data/shift in the same cycle; with no grant they SHALL be zero.
REQ-023 A BS_LAT-deep valid+ID pipeline SHALL track each issue; when its tail is valid, bs_out and the tagged ID SHALL be pushed into the response FIFO that cycle.
REQ-024 Response FIFO: depth DEPTH, first-word-fall-through; rsp_valid = (count != 0); pop on rsp_valid && rsp_ready; order equals issue order.
REQ-025 Simultaneous push and pop SHALL leave count unchanged; push into a full FIFO is unreachable by REQ-020 and SHALL be flagged by an assertion in simulation.
REQ-026 inflight counter: +1 on issue, -1 on pipeline tail push, both same cycle = unchanged; range 0..BS_LAT.
REQ-027 With rsp_ready held high and a requester continuously valid, sustained throughput SHALL be one response per cycle after BS_LAT+1 cycles of latency (issue to rsp_valid).
REQ-028 rsp_data/rsp_id SHALL stay stable while rsp_valid && !rsp_ready.

Reset
REQ-029 reset_n low SHALL asynchronously clear p to 0, inflight to 0, FIFO pointers/count to 0, ID pipeline valids to 0.
REQ-030 During reset: req_ready = 0, rsp_valid = 0, rsp_data = 0, rsp_id = 0, bs_in = 0, bs_shift = 0.
REQ-031 Reset mid-operation SHALL discard all in-flight and buffered responses; first grant after release follows pointer 0.

Configuration
REQ-032 Macro BS_ARBITER_FIXED_PRIO_EN: when defined, grant SHALL be fixed priority (lowest index wins) and p is not implemented; when undefined, round-robin per REQ-021.

Verification
REQ-033 All NREQ valid continuously, rsp_ready=1 -> grants 0,1,2,3,0,... one per cycle; rsp_id sequence 0,1,2,3,... first rsp_valid BS_LAT+1 cycles after first grant.
REQ-034 Only requester 2 valid, data=0x0102...10, shift=3 -> rsp_id=2, rsp_data equals shifter model output for shift 3, issued back-to-back.
REQ-035 rsp_ready=0 with requests pending -> exactly DEPTH issues, then req_ready=0 until rsp_ready=1; no response lost or reordered.
REQ-036 reset_n pulsed low with inflight=1 and FIFO count=2 -> all outputs zero immediately, no stale rsp_valid after release.
REQ-037 Build with BS_ARBITER_FIXED_PRIO_EN, requesters 1 and 3 always valid -> requester 1 granted every cycle, 3 starved.
